// File: rtl/sme_aes_seq_if.sv
// Request, response and sme_crypto-facing signals of the AES column sequencer.
// Share arrays are packed as [share][bit].
interface sme_aes_seq_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SMAX = 3
);
    logic                       flush;
    logic                       req_valid;
    logic                       req_ready;
    logic [1:0]                 req_op;
    logic [SMAX-1:0][XLEN-1:0]  req_rs1;
    logic [SMAX-1:0][XLEN-1:0]  req_rs2;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [SMAX-1:0][XLEN-1:0]  rsp_rd;
    logic                       cry_valid;
    logic                       cry_ready;
    logic                       cry_flush;
    logic                       cry_op_aeses;
    logic                       cry_op_aesesm;
    logic                       cry_op_aesds;
    logic                       cry_op_aesdsm;
    logic [1:0]                 cry_bs;
    logic [SMAX-1:0][XLEN-1:0]  cry_rs1;
    logic [SMAX-1:0][XLEN-1:0]  cry_rs2;
    logic [SMAX-1:0][XLEN-1:0]  cry_rd;

    modport slave (
        input  flush, req_valid, req_op, req_rs1, req_rs2, rsp_ready, cry_ready, cry_rd,
        output req_ready, rsp_valid, rsp_rd, cry_valid, cry_flush,
               cry_op_aeses, cry_op_aesesm, cry_op_aesds, cry_op_aesdsm,
               cry_bs, cry_rs1, cry_rs2
    );

    modport master (
        output flush, req_valid, req_op, req_rs1, req_rs2, rsp_ready, cry_ready, cry_rd,
        input  req_ready, rsp_valid, rsp_rd, cry_valid, cry_flush,
               cry_op_aeses, cry_op_aesesm, cry_op_aesds, cry_op_aesdsm,
               cry_bs, cry_rs1, cry_rs2
    );
endinterface

// File: rtl/sme_aes_seq.sv
// Column-level sequencer: runs four byte-select steps through sme_crypto,
// chaining each masked result into the next step's rs1, all share-wise.
module sme_aes_seq #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SMAX = 3
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    sme_aes_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    typedef logic [SMAX-1:0][XLEN-1:0] shares_t;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [1:0] op_q, op_d;
    shares_t    acc_q, acc_d;
    shares_t    src_q, src_d;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            step_q  <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        step_d            = step_q;
        op_d              = op_q;
        acc_d             = acc_q;
        src_d             = src_q;
        bus.req_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.cry_valid     = 1'b0;
        bus.cry_op_aeses  = 1'b0;
        bus.cry_op_aesesm = 1'b0;
        bus.cry_op_aesds  = 1'b0;
        bus.cry_op_aesdsm = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    src_d   = bus.req_rs2;
                    acc_d   = bus.req_rs1;
                    step_d  = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                bus.cry_valid     = 1'b1;
                bus.cry_op_aeses  = (op_q == 2'd0);
                bus.cry_op_aesesm = (op_q == 2'd1);
                bus.cry_op_aesds  = (op_q == 2'd2);
                bus.cry_op_aesdsm = (op_q == 2'd3);
                if (bus.cry_ready) begin
                    acc_d = bus.cry_rd;
                    if (step_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides every update above: only the state and step counter move.
        if (bus.flush) begin
            state_d = IDLE;
            step_d  = '0;
            op_d    = op_q;
            acc_d   = acc_q;
            src_d   = src_q;
        end
    end

    assign bus.cry_flush = bus.flush;
    assign bus.cry_bs    = step_q;
    assign bus.cry_rs1   = acc_q;
    assign bus.cry_rs2   = src_q;
    assign bus.rsp_rd    = acc_q;

endmodule

// File: tb/tb_sme_aes_seq.sv
// Bench for sme_aes_seq: plays sme_crypto with a masked byte-op model and checks
// recombined column results against an AES-arithmetic reference.
module tb_sme_aes_seq;
    localparam int unsigned XLEN = 32;
    localparam int unsigned SMAX = 2;
    localparam int unsigned LAT  = 4;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    always #5 g_clk = ~g_clk;

    sme_aes_seq_if #(.XLEN(XLEN), .SMAX(SMAX)) bus ();

    sme_aes_seq #(.XLEN(XLEN), .SMAX(SMAX)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        return (n == 0) ? v : ((v << n) | (v >> (32 - n)));
    endfunction

    // Contribution of one source byte before rotation into its column position.
    function automatic logic [31:0] byte_word(input logic [1:0] op, input logic [7:0] x);
        logic [7:0] s;
        case (op)
            2'd0: return {24'h0, sbox[x]};
            2'd1: begin
                s = sbox[x];
                return {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
            end
            2'd2: return {24'h0, isbox[x]};
            default: begin
                s = isbox[x];
                return {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)};
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_col(input logic [1:0] op, input logic [31:0] rs1,
                                            input logic [31:0] rs2);
        logic [31:0] acc;
        acc = rs1;
        for (int unsigned i = 0; i < 4; i++)
            acc = acc ^ rotl32(byte_word(op, rs2[8*i +: 8]), 8*i);
        return acc;
    endfunction

    // sme_crypto stand-in: computes the step on recombined data, then remasks.
    function automatic logic [63:0] crypto_step();
        logic [1:0]  op;
        logic [31:0] src;
        logic [31:0] t;
        logic [31:0] m;
        int unsigned bs;
        op  = bus.cry_op_aesesm ? 2'd1 : bus.cry_op_aesds ? 2'd2 : bus.cry_op_aesdsm ? 2'd3 : 2'd0;
        bs  = int'(bus.cry_bs);
        src = bus.cry_rs2[0] ^ bus.cry_rs2[1];
        t   = rotl32(byte_word(op, src[8*bs +: 8]), 8*bs);
        m   = $urandom;
        return {bus.cry_rs1[1] ^ m, bus.cry_rs1[0] ^ t ^ m};
    endfunction

    task automatic run_col(input logic [1:0] op, input logic [31:0] v1, input logic [31:0] m1,
                           input logic [31:0] v2, input logic [31:0] m2,
                           input int unsigned hold, input int flush_step, input bit rst_done,
                           output logic [31:0] res);
        int unsigned step;
        int unsigned cnt;
        int unsigned vcycles;
        int unsigned seen;
        bit          flushed;
        logic [31:0] exp_res;
        logic [63:0] held;
        step    = 0;
        cnt     = 0;
        vcycles = 0;
        flushed = 1'b0;
        res     = '0;
        exp_res = ref_col(op, v1, v2);

        check("accept_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_rs1[0] = v1 ^ m1;
        bus.req_rs1[1] = m1;
        bus.req_rs2[0] = v2 ^ m2;
        bus.req_rs2[1] = m2;
        cyc();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_rs1   = {$urandom, $urandom};
        bus.req_rs2   = {$urandom, $urandom};

        for (int c = 0; c < 64 && step < 4 && !flushed; c++) begin
            check("step_outputs",
                  64'({bus.cry_valid, bus.rsp_valid, bus.req_ready, bus.cry_bs,
                       bus.cry_op_aesdsm, bus.cry_op_aesds, bus.cry_op_aesesm, bus.cry_op_aeses}),
                  64'({1'b1, 1'b0, 1'b0, 2'(step), 4'(4'b0001 << op)}));
            vcycles++;
            cnt++;
            if (flush_step == int'(step) && cnt == 2) begin
                bus.flush     = 1'b1;
                bus.cry_ready = 1'b1;
                bus.cry_rd    = {$urandom, $urandom};
                #1;
                check("cry_flush_pulse", 64'(bus.cry_flush), 64'd1);
                cyc();
                bus.flush     = 1'b0;
                bus.cry_ready = 1'b0;
                #1;
                check("flush_idle", 64'({bus.req_ready, bus.rsp_valid, bus.cry_valid, bus.cry_flush}),
                      64'(4'b1000));
                flushed = 1'b1;
            end else begin
                if (cnt == LAT) begin
                    bus.cry_ready = 1'b1;
                    bus.cry_rd    = crypto_step();
                    cnt = 0;
                    step++;
                end else begin
                    bus.cry_ready = 1'b0;
                end
                cyc();
            end
        end
        bus.cry_ready = 1'b0;

        if (flushed) begin
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (bus.rsp_valid || bus.cry_valid) seen++;
                cyc();
            end
            check("flush_no_rsp", 64'(seen), 64'd0);
        end else begin
            check("steps_done", 64'(step), 64'd4);
            check("valid_cycles", 64'(vcycles), 64'(4 * LAT));
            check("done_outputs", 64'({bus.rsp_valid, bus.cry_valid, bus.req_ready}), 64'(3'b100));
            res = bus.rsp_rd[0] ^ bus.rsp_rd[1];
            check("result", 64'(res), 64'(exp_res));
            held = bus.rsp_rd;
            for (int unsigned h = 0; h < hold; h++) begin
                bus.cry_ready = 1'b1;
                bus.cry_rd    = {$urandom, $urandom};
                cyc();
                check("hold_ctl", 64'({bus.rsp_valid, bus.req_ready, bus.cry_valid}), 64'(3'b100));
                check("hold_rd", bus.rsp_rd, held);
            end
            bus.cry_ready = 1'b0;
            if (rst_done) begin
                g_resetn = 1'b0;
                cyc();
                check("rst_ctl", 64'({bus.req_ready, bus.rsp_valid, bus.cry_valid}), 64'(3'b100));
                check("rst_rd", bus.rsp_rd, 64'd0);
                check("rst_rs1", bus.cry_rs1, 64'd0);
                check("rst_rs2", bus.cry_rs2, 64'd0);
                g_resetn = 1'b1;
                cyc();
            end else begin
                bus.rsp_ready = 1'b1;
                cyc();
                bus.rsp_ready = 1'b0;
                check("rsp_handshake", 64'({bus.req_ready, bus.rsp_valid}), 64'(2'b10));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  inv;
        logic [7:0]  s;
        logic [31:0] res;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[a]  = s;
            isbox[s] = 8'(a);
        end

        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.rsp_ready = 1'b0;
        bus.cry_ready = 1'b0;
        bus.cry_rd    = '0;

        g_resetn = 1'b0;
        cyc();
        cyc();
        check("reset_ctl",
              64'({bus.req_ready, bus.rsp_valid, bus.cry_valid, bus.cry_op_aeses, bus.cry_op_aesesm,
                   bus.cry_op_aesds, bus.cry_op_aesdsm, bus.cry_bs, bus.cry_flush}),
              64'(11'b100_0000_00_0));
        check("reset_rd", bus.rsp_rd, 64'd0);
        check("reset_rs1", bus.cry_rs1, 64'd0);
        check("reset_rs2", bus.cry_rs2, 64'd0);
        g_resetn = 1'b1;
        cyc();

        run_col(2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 0, -1, 1'b0, res);
        check("plan_aesesm", 64'(res), 64'h63636363);
        run_col(2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h11111111, 0, -1, 1'b0, res);
        check("plan_aeses", 64'(res), 64'h9C9C9C9C);
        run_col(2'd2, 32'h0, $urandom, 32'h0, $urandom, 10, -1, 1'b0, res);
        check("plan_aesds", 64'(res), 64'h52525252);

        run_col(2'd3, $urandom, $urandom, $urandom, $urandom, 0, 2, 1'b0, res);
        run_col(2'd3, $urandom, $urandom, $urandom, $urandom, 1, -1, 1'b0, res);

        // Flush wins over a request offered in the same cycle.
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_rs1   = {$urandom, $urandom};
        bus.req_rs2   = {$urandom, $urandom};
        cyc();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check("flush_over_req", 64'({bus.req_ready, bus.cry_valid}), 64'(2'b10));
        cyc();

        for (int i = 0; i < 8; i++)
            run_col(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                    32'(i % 3), -1, 1'b0, res);

        run_col(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, 0,
                int'($urandom_range(0, 3)), 1'b0, res);
        run_col(2'd1, $urandom, $urandom, $urandom, $urandom, 2, -1, 1'b1, res);
        run_col(2'd3, $urandom, $urandom, $urandom, $urandom, 0, -1, 1'b0, res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sme_aes_seq.md
# sme_aes_seq

Column-level sequencer for the SME masked AES byte datapath. It accepts one 32-bit AES column operation as SMAX shares and issues four byte-select steps (bs = 0..3) to the shared `sme_crypto` unit. Each step's `rd` is chained into the next step's `rs1`, and the final accumulated column is returned on a valid/ready response port. It sits between the SME issue logic and `sme_crypto` and owns that unit's `valid`, `bs`, `rs1`, `rs2`, op-select and `flush` inputs.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- SMAX, 3: number of hardware shares (SM = SMAX-1, XL = XLEN-1).

- g_clk  in  1  clock
- g_resetn  in  1  reset: synchronous, active-low, sampled on g_clk
- flush  in  1  abort the current column; no response is produced
- req_valid  in  1  column request valid
- req_ready  out  1  sequencer can accept a request (state IDLE)
- req_op  in  2  0 aeses, 1 aesesm, 2 aesds, 3 aesdsm
- req_rs1  in  [XL:0] x [SM:0]  accumulator seed shares
- req_rs2  in  [XL:0] x [SM:0]  state column shares (sbox source)
- rsp_valid  out  1  result valid (state DONE)
- rsp_ready  in  1  consumer accepts result
- rsp_rd  out  [XL:0] x [SM:0]  result shares
- cry_valid  out  1  to sme_crypto valid
- cry_ready  in  1  from sme_crypto ready
- cry_flush  out  1  to sme_crypto flush
- cry_op_aeses, cry_op_aesesm, cry_op_aesds, cry_op_aesdsm  out  1 each  one-hot op select
- cry_bs  out  2  byte select
- cry_rs1, cry_rs2  out  [XL:0] x [SM:0]  operand shares
- cry_rd  in  [XL:0] x [SM:0]  step result shares

## Operation
- States: IDLE, STEP, DONE.
- IDLE: req_ready=1. On req_valid, latch req_op into op_q, req_rs2 into src_q and req_rs1 into acc_q; set step_q=0; go to STEP.
- STEP: cry_valid=1, cry_bs=step_q, cry_rs1=acc_q, cry_rs2=src_q. The op-select line matching op_q is 1 and the others are 0.
  - On cry_ready, set acc_q<=cry_rd.
  - If step_q==3, go to DONE; otherwise step_q<=step_q+1.
- DONE: rsp_valid=1, rsp_rd=acc_q. On rsp_ready, go to IDLE.
- All share arrays are held and updated share-wise. No share is ever XORed with another share inside this block; unmasking is forbidden.
- Op-selects and cry_valid are 0 outside STEP.
- cry_flush=1 in the cycle flush=1, in any state.
- flush in any state: go to IDLE, with no rsp_valid. step_q is cleared; acc_q and src_q are retained but ignored.
- flush has priority over a simultaneous req_valid, cry_ready or rsp_ready in the same cycle.
- Result: rsp_rd = req_rs1 XOR the XOR over byte i of (byte-op(req_rs2 byte i) rotated into position i). With mix ops this is a full (Inv)MixColumns column.

## Timing
- Reset (g_resetn=0 at a clock edge): state IDLE, step_q=0, acc_q=0, src_q=0, op_q=0.
  - After reset: req_ready=1; rsp_valid=0, cry_valid=0, all op-selects 0, cry_bs=0, cry_flush=0, rsp_rd=0, cry_rs1=0, cry_rs2=0.
- Request accepted at edge N: cry_valid=1 from cycle N+1.
- Each step lasts until cry_ready. With the current sme_crypto this is 4 cycles per step, so 16 cycles of cry_valid.
- rsp_valid rises the cycle after the fourth cry_ready.
- Nominal request-accept to rsp_valid: 17 cycles.
- rsp_valid is held with stable rsp_rd until rsp_ready.
- Back-to-back: req_ready=1 the cycle after the rsp_ready handshake. There is no request/response overlap.
- cry_ready while not in STEP is ignored.
- Reset mid-operation: same as flush, plus all registers are zeroed.

## Test plan
- SMAX=2, req_op=1 (aesesm), rs2 shares {0,0}, rs1 {0,0} -> after 4 steps (bs 0,1,2,3), share0 XOR share1 = 0x63636363; rsp_valid exactly 1 cycle after the 4th cry_ready.
- req_op=0 (aeses), rs2 {0x11111111, 0x11111111} (value 0), rs1 {0xFFFFFFFF, 0} -> recombined rsp_rd = 0x9C9C9C9C.
- req_op=2 (aesds), value 0, rs1 0 -> recombined rsp_rd = 0x52525252; only cry_op_aesds is asserted throughout STEP.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_rd stable; req_ready=0 and no cry_valid. Then rsp_ready=1 -> req_ready=1 next cycle.
- flush asserted in STEP at step 2 -> cry_flush pulses for 1 cycle; IDLE next cycle; no rsp_valid ever. A following request yields the correct result.
- g_resetn=0 during DONE -> next cycle rsp_valid=0, req_ready=1, rsp_rd=0.
